// File: rtl/golden_nonce_uart.sv
// golden_nonce_uart: queues golden nonces in a small FIFO and sends each as four 8N1 UART bytes, LSB byte first
module golden_nonce_uart #(
    parameter int BAUD_DIV  = 434,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                 hash_clk,
    input  logic                 reset,
    input  logic                 nonce_valid,
    input  logic [31:0]          nonce,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_LOG2:0]   fifo_count
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t               state_q;
    logic [31:0]          mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_q, rd_q;
    logic [FIFO_LOG2:0]   cnt_q, cnt_d;
    logic                 ovf_q, tx_q;
    logic [31:0]          sh_q;
    logic [15:0]          baud_q;
    logic [2:0]           bit_q;
    logic [1:0]           byte_q;
    logic                 full, pop, push, baud_end;
    assign full       = cnt_q == (FIFO_LOG2+1)'(DEPTH);
    assign pop        = state_q == IDLE && cnt_q != '0;
    assign push       = nonce_valid && (!full || pop);
    assign baud_end   = baud_q == 16'(BAUD_DIV - 1);
    assign tx         = tx_q;
    assign busy       = state_q != IDLE || cnt_q != '0;
    assign overflow   = ovf_q;
    assign fifo_count = cnt_q;
    // next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
    // FIFO storage, wrapping pointers and the sticky drop flag
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= nonce;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
            if (nonce_valid && !push) ovf_q <= 1'b1;
        end
    end
    // framing FSM; the shift register drops one bit per data bit so the next byte lands at bit 0
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            sh_q    <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    tx_q    <= 1'b0;
                    sh_q    <= mem_q[rd_q];
                    byte_q  <= '0;
                    baud_q  <= '0;
                end
                START: if (baud_end) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    tx_q    <= sh_q[0];
                    baud_q  <= '0;
                end else baud_q <= baud_q + 1'b1;
                DATA: if (baud_end) begin
                    baud_q <= '0;
                    sh_q   <= sh_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                        tx_q  <= sh_q[1];
                    end
                end else baud_q <= baud_q + 1'b1;
                STOP: if (baud_end) begin
                    baud_q <= '0;
                    if (byte_q != 2'd3) begin
                        byte_q  <= byte_q + 1'b1;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                end else baud_q <= baud_q + 1'b1;
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_golden_nonce_uart.sv
// tb_golden_nonce_uart: two instances (BAUD_DIV 4 and 2) checked every cycle against a word-level line model
module tb_golden_nonce_uart;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic [1:0]  r = 2'b11, v = 2'b00;
    logic [31:0] n [2];
    logic [1:0]  tx, bsy, ovf;
    logic [2:0]  fc [2];
    golden_nonce_uart #(.BAUD_DIV(4), .FIFO_LOG2(2)) u0 (.hash_clk(clk), .reset(r[0]), .nonce_valid(v[0]),
        .nonce(n[0]), .tx(tx[0]), .busy(bsy[0]), .overflow(ovf[0]), .fifo_count(fc[0]));
    golden_nonce_uart #(.BAUD_DIV(2), .FIFO_LOG2(2)) u1 (.hash_clk(clk), .reset(r[1]), .nonce_valid(v[1]),
        .nonce(n[1]), .tx(tx[1]), .busy(bsy[1]), .overflow(ovf[1]), .fifo_count(fc[1]));
    int ncmp = 0, nfail = 0, cyc = 0;
    bit live = 0;
    // model: FIFO contents, word in flight and position within its 40*BAUD_DIV-cycle frame
    logic [31:0] mq [2][4];
    int          mh [2], mn [2], pos [2];
    bit          infl [2], movf [2];
    logic [31:0] cw [2];
    // line decoder and event log
    bit          ract [2], pb [2];
    int          rc [2], gotn [2], nst [2], fall [2];
    logic [31:0] rw [2];
    logic [31:0] got [2][64];
    int          gst [2][64];

    function automatic int bdv(input int i);
        return i ? 2 : 4;
    endfunction

    function automatic logic etx(input int i);
        int k, b;
        if (!infl[i]) return 1'b1;
        k = pos[i] / bdv(i);
        b = k % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cw[i][(k / 10) * 8 + b - 1];
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s[%0d]: got %h expected %h at cycle %0d", nm, i, a, e, cyc);
        end
    endtask

    task automatic check_cycle;
        for (int i = 0; i < 2; i++) begin
            if (live) begin
                chk("tx", i, 32'(tx[i]), 32'(etx(i)));
                chk("busy", i, 32'(bsy[i]), 32'(infl[i] || mn[i] != 0));
                chk("overflow", i, 32'(ovf[i]), 32'(movf[i]));
                chk("fifo_count", i, 32'(fc[i]), mn[i]);
            end
            if (r[i]) ract[i] = 0;
            else begin
                if (!ract[i] && tx[i] === 1'b0) begin
                    ract[i] = 1;
                    rc[i] = 0;
                    if (gotn[i] < 64) gst[i][gotn[i]] = cyc;
                    nst[i]++;
                end
                if (ract[i]) begin
                    if (rc[i] % bdv(i) == bdv(i) / 2) begin
                        int k, b;
                        k = rc[i] / bdv(i);
                        b = k % 10;
                        if (b >= 1 && b <= 8) rw[i][(k / 10) * 8 + b - 1] = tx[i];
                    end
                    rc[i]++;
                    if (rc[i] == 40 * bdv(i)) begin
                        ract[i] = 0;
                        if (gotn[i] < 64) got[i][gotn[i]] = rw[i];
                        gotn[i]++;
                    end
                end
            end
            if (pb[i] && !bsy[i]) fall[i] = cyc;
            pb[i] = bsy[i];
        end
    endtask

    task automatic model_update;
        cyc++;
        if (r == 2'b11) live = 1;
        for (int i = 0; i < 2; i++) begin
            if (r[i]) begin
                mh[i] = 0; mn[i] = 0; infl[i] = 0; pos[i] = 0; movf[i] = 0;
            end else begin
                if (!infl[i] && mn[i] != 0) begin
                    cw[i] = mq[i][mh[i]];
                    mh[i] = (mh[i] + 1) % 4;
                    mn[i]--;
                    infl[i] = 1;
                    pos[i] = 0;
                end else if (infl[i]) begin
                    pos[i]++;
                    if (pos[i] == 40 * bdv(i)) infl[i] = 0;
                end
                if (v[i]) begin
                    if (mn[i] < 4) begin
                        mq[i][(mh[i] + mn[i]) % 4] = n[i];
                        mn[i]++;
                    end else movf[i] = 1;
                end
            end
        end
    endtask

    task automatic step;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wait_quiet(input int budget);
        int t = 0;
        while ((bsy != 2'b00 || tx != 2'b11) && t < budget) begin
            step();
            t++;
        end
        ncmp++;
        if (t >= budget) begin
            nfail++;
            $display("FAIL quiet: still busy after %0d cycles, required idle", budget);
        end
        step();
    endtask

    task automatic do_reset;
        r = 2'b11;
        step();
        r = 2'b00;
    endtask

    initial begin
        int b [2];
        int c, p;
        n[0] = '0; n[1] = '0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", i, 32'(tx[i]), 1);
            chk("rst_busy", i, 32'(bsy[i]), 0);
            chk("rst_ovf", i, 32'(ovf[i]), 0);
            chk("rst_cnt", i, 32'(fc[i]), 0);
        end
        step();
        // single nonce
        for (int i = 0; i < 2; i++) b[i] = gotn[i];
        p = cyc;
        v = 2'b11; n[0] = 32'h12345678; n[1] = 32'h12345678;
        step();
        v = 2'b00;
        wait_quiet(500);
        for (int i = 0; i < 2; i++) begin
            chk("a_latency", i, gst[i][b[i]] - p, 2);
            chk("a_length", i, fall[i] - gst[i][b[i]], i ? 80 : 160);
            chk("a_words", i, gotn[i] - b[i], 1);
            chk("a_word", i, got[i][b[i]], 32'h12345678);
        end
        // overflow: six pulses, the sixth is dropped
        for (int i = 0; i < 2; i++) b[i] = gotn[i];
        for (int k = 1; k <= 6; k++) begin
            v = 2'b11; n[0] = k; n[1] = k;
            step();
            for (int i = 0; i < 2; i++) chk("b_ovf", i, 32'(ovf[i]), k == 6);
        end
        v = 2'b00;
        for (int i = 0; i < 2; i++) chk("b_cnt", i, 32'(fc[i]), 4);
        wait_quiet(2000);
        for (int i = 0; i < 2; i++) begin
            chk("b_words", i, gotn[i] - b[i], 5);
            for (int j = 0; j < 5; j++) chk("b_word", i, got[i][b[i] + j], j + 1);
            chk("b_ovf_end", i, 32'(ovf[i]), 1);
        end
        do_reset();
        // push into a full FIFO on the pop cycle
        for (int i = 0; i < 2; i++) begin
            b[i] = gotn[i];
            c = cyc;
            for (int k = 0; k < 5; k++) begin
                v = 2'(1 << i); n[0] = 32'hA0 + k; n[1] = 32'hA0 + k;
                step();
            end
            v = 2'b00;
            while (cyc < c + 2 + 40 * bdv(i)) step();
            v = 2'(1 << i); n[0] = 32'hBEEF; n[1] = 32'hBEEF;
            step();
            v = 2'b00;
            chk("c_cnt", i, 32'(fc[i]), 4);
            chk("c_ovf", i, 32'(ovf[i]), 0);
            wait_quiet(2000);
            chk("c_words", i, gotn[i] - b[i], 6);
            chk("c_last", i, got[i][b[i] + 5], 32'hBEEF);
            chk("c_ovf_end", i, 32'(ovf[i]), 0);
        end
        // reset during byte 1, data bit 3, with two words queued
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            v = 2'b11; n[0] = 32'hC0DE0000 + k; n[1] = 32'hC0DE0000 + k;
            step();
        end
        v = 2'b00;
        for (int i = 1; i >= 0; i--) begin
            while (cyc < c + 2 + 14 * bdv(i) + 1) step();
            r = 2'(1 << i);
            step();
            r = 2'b00;
            chk("d_tx", i, 32'(tx[i]), 1);
            chk("d_cnt", i, 32'(fc[i]), 0);
            chk("d_busy", i, 32'(bsy[i]), 0);
            chk("d_ovf", i, 32'(ovf[i]), 0);
        end
        for (int i = 0; i < 2; i++) b[i] = nst[i];
        repeat (400) step();
        for (int i = 0; i < 2; i++) chk("d_silent", i, nst[i] - b[i], 0);
        // back-to-back words
        for (int i = 0; i < 2; i++) b[i] = gotn[i];
        v = 2'b11; n[0] = 32'h11; n[1] = 32'h11;
        step();
        n[0] = 32'h22; n[1] = 32'h22;
        step();
        v = 2'b00;
        wait_quiet(1000);
        for (int i = 0; i < 2; i++) begin
            chk("e_gap", i, gst[i][b[i] + 1] - gst[i][b[i]], i ? 81 : 161);
            chk("e_w0", i, got[i][b[i]], 32'h11);
            chk("e_w1", i, got[i][b[i] + 1], 32'h22);
        end
        // all-ones then all-zeros
        for (int i = 0; i < 2; i++) b[i] = gotn[i];
        v = 2'b11; n[0] = 32'hFFFFFFFF; n[1] = 32'hFFFFFFFF;
        step();
        n[0] = 32'h0; n[1] = 32'h0;
        step();
        v = 2'b00;
        wait_quiet(1000);
        for (int i = 0; i < 2; i++) begin
            chk("f_w0", i, got[i][b[i]], 32'hFFFFFFFF);
            chk("f_w1", i, got[i][b[i] + 1], 32'h0);
        end
        // randomized traffic with bursts, idle spells and occasional resets
        for (int t = 0; t < 4000; t++) begin
            int lim;
            lim = ((t / 500) % 2) ? 2 : 60;
            for (int i = 0; i < 2; i++) begin
                v[i] = $urandom_range(0, lim) == 0;
                n[i] = $urandom;
                r[i] = $urandom_range(0, 999) == 0;
            end
            step();
        end
        v = 2'b00; r = 2'b00;
        wait_quiet(2000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
